// File: rtl/roe_mc_ctrl_pkg.sv
// ============================================================================
// Module  : roe_mc_ctrl_pkg
// Brief   : Shared encodings and types for the R.O.E. multi-cycle controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package roe_mc_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_REG   = 3'd0,
        OP_ARITH = 3'd1,
        OP_SHIFT = 3'd2,
        OP_HARD  = 3'd3,
        OP_SLT   = 3'd4,
        OP_XOR   = 3'd5,
        OP_AND   = 3'd6,
        OP_OR    = 3'd7
    } op_code_t;

    typedef enum logic [1:0] {
        FN_REDEF  = 2'd0,
        FN_LW     = 2'd1,
        FN_SW     = 2'd2,
        FN_BRANCH = 2'd3
    } func_code_t;

    typedef enum logic [3:0] {
        ALU_NOP    = 4'd0,
        ALU_ADD    = 4'd1,
        ALU_SUB    = 4'd2,
        ALU_SHIFTL = 4'd3,
        ALU_SHIFTR = 4'd4,
        ALU_SLB    = 4'd5,
        ALU_SLT    = 4'd6,
        ALU_XOR    = 4'd7,
        ALU_AND    = 4'd8,
        ALU_OR     = 4'd9,
        ALU_BNZ    = 4'd10
    } alu_code_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } ctrl_state_t;

    localparam logic [3:0] HALT_OPERAND = 4'hF;

    typedef struct packed {
        alu_code_t alu;
        logic      is_lw;
        logic      is_sw;
        logic      is_br;
        logic      is_halt;
        logic      wr_en;
    } ctrl_dec_t;

    function automatic logic is_mem_op(input ctrl_dec_t d);
        return d.is_lw | d.is_sw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/roe_instr_decode.sv
// ============================================================================
// Module  : roe_instr_decode
// Brief   : Combinational instruction decoder: instruction word to ctrl_dec_t.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module roe_instr_decode
    import roe_mc_ctrl_pkg::*;
#(
    parameter int INSTR_W = 9
) (
    input  logic [INSTR_W-1:0] instr_i,
    output ctrl_dec_t          dec_o
);

    op_code_t   op_w;
    func_code_t func_w;

    assign op_w   = op_code_t'(instr_i[8:6]);
    assign func_w = func_code_t'(instr_i[1:0]);

    always_comb begin
        dec_o       = '0;
        dec_o.alu   = ALU_NOP;
        dec_o.wr_en = 1'b1;
        case (op_w)
            OP_ARITH: dec_o.alu = instr_i[0] ? ALU_SUB : ALU_ADD;
            OP_SHIFT: dec_o.alu = instr_i[0] ? ALU_SHIFTR : ALU_SHIFTL;
            OP_HARD:  dec_o.alu = ALU_SLB;
            OP_SLT:   dec_o.alu = ALU_SLT;
            OP_XOR:   dec_o.alu = ALU_XOR;
            OP_AND:   dec_o.alu = ALU_AND;
            OP_OR:    dec_o.alu = ALU_OR;
            OP_REG: begin
                case (func_w)
                    FN_LW: begin
                        dec_o.alu   = ALU_ADD;
                        dec_o.is_lw = 1'b1;
                    end
                    FN_SW: begin
                        dec_o.alu   = ALU_ADD;
                        dec_o.is_sw = 1'b1;
                        dec_o.wr_en = 1'b0;
                    end
                    FN_BRANCH: begin
                        dec_o.alu   = ALU_BNZ;
                        dec_o.is_br = 1'b1;
                        dec_o.wr_en = 1'b0;
                    end
                    FN_REDEF: begin
                        dec_o.alu = ALU_SLB;
                        // A REDEF carrying the all-ones operand is the halt instruction
                        if (instr_i[5:2] == HALT_OPERAND) begin
                            dec_o.is_halt = 1'b1;
                            dec_o.wr_en   = 1'b0;
                        end
                    end
                endcase
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/roe_mc_ctrl.sv
// ============================================================================
// Module  : roe_mc_ctrl
// Brief   : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with ack timeouts.
//           Define ROE_CTRL_PERF_EN to add cycle/instruction counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module roe_mc_ctrl
    import roe_mc_ctrl_pkg::*;
#(
    parameter int INSTR_W     = 9,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               instr_req,
    input  logic               instr_ack,
    input  logic [INSTR_W-1:0] instr,
    output logic [3:0]         alu_op,
    input  logic               alu_zero,
    output logic               reg_we,
    output logic               wb_sel,
    output logic               pc_en,
    output logic               pc_load,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef ROE_CTRL_PERF_EN
    ,
    output logic [15:0]        cyc_cnt,
    output logic [15:0]        instr_cnt
`endif
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t        state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    ctrl_dec_t          dec_w, dec_q, dec_d;
    logic               taken_q, taken_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               start_ok;
    logic               timeout_hit;

    roe_instr_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .instr_i (instr_q),
        .dec_o   (dec_w)
    );

    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_HALT) ||
                                   (state_q == ST_ERROR));
    // Counter holds the number of cycles already waited, so this is the last allowed wait cycle
    assign timeout_hit = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        dec_d    = dec_q;
        taken_d  = taken_q;
        to_cnt_d = '0;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_ack) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                dec_d = dec_w;
                if (dec_w.is_halt) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                taken_d = dec_q.is_br && !alu_zero;
                state_d = is_mem_op(dec_q) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_HALT, ST_ERROR: begin
                if (start_ok) begin
                    state_d = ST_FETCH;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            dec_q    <= '0;
            taken_q  <= 1'b0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            dec_q    <= dec_d;
            taken_q  <= taken_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign instr_req = (state_q == ST_FETCH);
    assign dmem_req  = (state_q == ST_MEM);
    assign dmem_we   = (state_q == ST_MEM) && dec_q.is_sw;
    assign reg_we    = (state_q == ST_WB) && dec_q.wr_en;
    assign wb_sel    = (state_q == ST_WB) && dec_q.is_lw;
    assign pc_load   = (state_q == ST_WB) && taken_q;
    assign pc_en     = (state_q == ST_WB) && !taken_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXEC)  || (state_q == ST_MEM)    ||
                       (state_q == ST_WB);
    assign alu_op    = dec_q.alu;
    assign done      = done_q;
    assign err       = err_q;

`ifdef ROE_CTRL_PERF_EN
    logic [15:0] cyc_cnt_q;
    logic [15:0] instr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else if (start_ok) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (busy) cyc_cnt_q <= cyc_cnt_q + 16'd1;
            // Retire on WB, or on the DECODE that hands off to HALT
            if ((state_q == ST_WB) || done_d) instr_cnt_q <= instr_cnt_q + 16'd1;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_roe_mc_ctrl.sv
// ============================================================================
// Module  : tb_roe_mc_ctrl
// Brief   : Self-checking bench: transaction-level timeline model vs roe_mc_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_roe_mc_ctrl;
    import roe_mc_ctrl_pkg::*;

    localparam int         TO     = 15;
    localparam logic [8:0] HALT_I = 9'b000_1111_00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       instr_ack = 1'b0;
    logic [8:0] instr = '0;
    logic       alu_zero = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       instr_req, reg_we, wb_sel, pc_en, pc_load, dmem_req, dmem_we, busy, done, err;
    logic [3:0] alu_op;
`ifdef ROE_CTRL_PERF_EN
    logic [15:0] cyc_cnt, instr_cnt;
`endif

    roe_mc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .instr_req (instr_req),
        .instr_ack (instr_ack),
        .instr     (instr),
        .alu_op    (alu_op),
        .alu_zero  (alu_zero),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .pc_en     (pc_en),
        .pc_load   (pc_load),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef ROE_CTRL_PERF_EN
        ,
        .cyc_cnt   (cyc_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One entry per clock: inputs to drive and the outputs expected during that cycle
    typedef struct {
        bit         rst_n, start, instr_ack, alu_zero, dmem_ack;
        logic [8:0] instr;
        bit         instr_req, reg_we, wb_sel, pc_en, pc_load, dmem_req, dmem_we, busy, done, err;
        bit [3:0]   alu_op;
        bit [15:0]  cyc, icnt;
        int         tag;
    } rec_t;

    rec_t       q[$];
    bit [3:0]   m_alu = '0;
    bit         m_err = 1'b0;
    bit [15:0]  m_cyc = '0;
    bit [15:0]  m_icnt = '0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc_i = 0;

    function automatic logic [3:0] model_alu(input logic [8:0] ins);
        case (ins[8:6])
            3'd0: begin
                case (ins[1:0])
                    2'd1, 2'd2: return ALU_ADD;
                    2'd3:       return ALU_BNZ;
                    default:    return ALU_SLB;
                endcase
            end
            3'd1:    return ins[0] ? ALU_SUB : ALU_ADD;
            3'd2:    return ins[0] ? ALU_SHIFTR : ALU_SHIFTL;
            3'd3:    return ALU_SLB;
            3'd4:    return ALU_SLT;
            3'd5:    return ALU_XOR;
            3'd6:    return ALU_AND;
            default: return ALU_OR;
        endcase
    endfunction

    function automatic logic [8:0] rand_instr();
        logic [8:0] ins;
        ins = 9'($urandom);
        if ($urandom_range(0, 9) < 5) begin
            if (ins[8:6] == 3'd0) ins[8:6] = 3'd1;
        end else begin
            ins[8:6] = 3'd0;
            if (ins[1:0] == 2'd0 && ins[5:2] == 4'hF) ins[2] = 1'b0;
        end
        return ins;
    endfunction

    function automatic rec_t blank(input bit in_busy);
        rec_t r;
        r           = '{default: 0};
        r.rst_n     = 1'b1;
        r.start     = in_busy ? 1'($urandom_range(0, 1)) : 1'b0;
        r.instr_ack = 1'($urandom_range(0, 1));
        r.dmem_ack  = 1'($urandom_range(0, 1));
        r.alu_zero  = 1'($urandom_range(0, 1));
        r.instr     = 9'($urandom);
        return r;
    endfunction

    task automatic push(input rec_t r, input bit start_acc, input bit retire);
        r.alu_op = m_alu;
        r.err    = m_err;
        r.cyc    = m_cyc;
        r.icnt   = m_icnt;
        q.push_back(r);
        if (start_acc) begin
            m_cyc  = '0;
            m_icnt = '0;
            m_err  = 1'b0;
        end else begin
            if (r.busy) m_cyc = m_cyc + 16'd1;
            if (retire) m_icnt = m_icnt + 16'd1;
        end
    endtask

    task automatic reset_cycles(input int n, input int tag);
        rec_t r;
        m_alu = '0; m_err = 1'b0; m_cyc = '0; m_icnt = '0;
        for (int i = 0; i < n; i++) begin
            r       = blank(1'b0);
            r.rst_n = 1'b0;
            r.tag   = (i == n - 1) ? tag : 0;
            push(r, 1'b0, 1'b0);
        end
    endtask

    task automatic idle_cycles(input int n, input int tag);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r     = blank(1'b0);
            r.tag = (i == 0) ? tag : 0;
            push(r, 1'b0, 1'b0);
        end
    endtask

    task automatic start_cycle();
        rec_t r;
        r       = blank(1'b0);
        r.start = 1'b1;
        push(r, 1'b1, 1'b0);
    endtask

    task automatic fetch_phase(input logic [8:0] ins, input int fwait, output bit ok);
        rec_t r;
        ok = 1'b0;
        for (int i = 0; i < TO; i++) begin
            r           = blank(1'b1);
            r.busy      = 1'b1;
            r.instr_req = 1'b1;
            r.instr_ack = (i == fwait);
            if (r.instr_ack) r.instr = ins;
            push(r, 1'b0, 1'b0);
            if (i == fwait) begin
                ok = 1'b1;
                return;
            end
        end
        m_err = 1'b1;
    endtask

    // st: 0 acked, 2 timed out, 3 reset asserted mid-wait
    task automatic mem_phase(input bit is_sw, input int mwait, input int abort_at, output int st);
        rec_t r;
        for (int i = 0; i < TO; i++) begin
            r          = blank(1'b1);
            r.busy     = 1'b1;
            r.dmem_req = 1'b1;
            r.dmem_we  = is_sw;
            r.dmem_ack = (i == mwait);
            if (i == abort_at) begin
                r.rst_n    = 1'b0;
                r.dmem_ack = 1'b0;
                r.tag      = 7;
                push(r, 1'b0, 1'b0);
                reset_cycles(2, 6);
                st = 3;
                return;
            end
            push(r, 1'b0, 1'b0);
            if (i == mwait) begin
                st = 0;
                return;
            end
        end
        m_err = 1'b1;
        st    = 2;
    endtask

    // st: 0 back in FETCH, 1 halted, 2 error, 3 reset
    task automatic run_instr(input logic [8:0] ins, input int fwait, input int mwait,
                             input bit zero, input int abort_at, input int wb_tag, output int st);
        rec_t r;
        bit   ok, lw, sw, br, hlt, taken;
        int   ms;
        lw  = (ins[8:6] == 3'd0) && (ins[1:0] == 2'd1);
        sw  = (ins[8:6] == 3'd0) && (ins[1:0] == 2'd2);
        br  = (ins[8:6] == 3'd0) && (ins[1:0] == 2'd3);
        hlt = (ins[8:6] == 3'd0) && (ins[1:0] == 2'd0) && (ins[5:2] == 4'hF);
        fetch_phase(ins, fwait, ok);
        if (!ok) begin
            st = 2;
            return;
        end
        r      = blank(1'b1);
        r.busy = 1'b1;
        push(r, 1'b0, hlt);
        m_alu = model_alu(ins);
        if (hlt) begin
            r      = blank(1'b0);
            r.done = 1'b1;
            r.tag  = 4;
            push(r, 1'b0, 1'b0);
            st = 1;
            return;
        end
        r          = blank(1'b1);
        r.busy     = 1'b1;
        r.alu_zero = zero;
        push(r, 1'b0, 1'b0);
        taken = br && !zero;
        if (lw || sw) begin
            mem_phase(sw, mwait, abort_at, ms);
            if (ms != 0) begin
                st = ms;
                return;
            end
        end
        r         = blank(1'b1);
        r.busy    = 1'b1;
        r.reg_we  = !(sw || br);
        r.wb_sel  = lw;
        r.pc_load = taken;
        r.pc_en   = !taken;
        r.tag     = wb_tag;
        push(r, 1'b0, 1'b1);
        st = 0;
    endtask

    task automatic prog(input int n);
        int st;
        start_cycle();
        for (int i = 0; i < n; i++)
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), -1, 0, st);
        run_instr(HALT_I, 0, 0, 1'b0, -1, 0, st);
        idle_cycles(2, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc_i, act, exp);
        end
    endtask

    initial begin
        rec_t        r;
        int          st;
        logic [13:0] got, want;

        reset_cycles(3, 6);
        idle_cycles(2, 0);
        start_cycle();
        run_instr(9'b001_000000, 0, 0, 1'b0, -1, 1, st);
        run_instr(HALT_I, 0, 0, 1'b0, -1, 0, st);
        idle_cycles(2, 0);
        start_cycle();
        run_instr(9'b000_0000_01, 0, 3, 1'b0, -1, 2, st);
        run_instr(9'b000_0000_10, 1, 0, 1'b0, -1, 0, st);
        run_instr(9'b000_0000_11, 0, 0, 1'b0, -1, 3, st);
        run_instr(9'b000_0000_11, 0, 0, 1'b1, -1, 0, st);
        run_instr(9'b001_000001, TO - 1, 0, 1'b0, -1, 0, st);
        run_instr(HALT_I, 0, 0, 1'b0, -1, 0, st);
        idle_cycles(1, 0);
        start_cycle();
        run_instr(9'b010_000000, TO + 5, 0, 1'b0, -1, 0, st);
        idle_cycles(3, 5);
        start_cycle();
        run_instr(9'b000_0000_01, 0, TO + 5, 1'b0, -1, 0, st);
        idle_cycles(2, 5);
        prog(40);
        start_cycle();
        run_instr(9'b000_0000_10, 0, 10, 1'b0, 2, 0, st);
        idle_cycles(2, 0);
        prog(25);

        while (q.size() > 0) begin
            r = q.pop_front();
            cyc_i++;
            @(negedge clk);
            got  = {instr_req, alu_op, reg_we, wb_sel, pc_en, pc_load, dmem_req, dmem_we,
                    busy, done, err};
            want = {r.instr_req, r.alu_op, r.reg_we, r.wb_sel, r.pc_en, r.pc_load, r.dmem_req,
                    r.dmem_we, r.busy, r.done, r.err};
            check("outputs", 32'(got), 32'(want));
`ifdef ROE_CTRL_PERF_EN
            check("counters", {cyc_cnt, instr_cnt}, {r.cyc, r.icnt});
`endif
            case (r.tag)
                1: check("add_wb", 32'({alu_op, reg_we, pc_en, pc_load}), 32'(7'b0001_110));
                2: check("lw_wb", 32'({reg_we, wb_sel}), 32'(2'b11));
                3: check("bnz_taken_wb", 32'({pc_load, pc_en}), 32'(2'b10));
                4: check("halt_entry", 32'({done, busy, reg_we}), 32'(3'b100));
                5: check("timeout_err", 32'({err, instr_req, dmem_req}), 32'(3'b100));
                6: check("reset_state", 32'(got), 32'd0);
                default: ;
            endcase
            rst_n     = r.rst_n;
            start     = r.start;
            instr_ack = r.instr_ack;
            instr     = r.instr;
            alu_zero  = r.alu_zero;
            dmem_ack  = r.dmem_ack;
            if (r.tag == 7) begin
                #1;
                check("reset_drop", 32'({dmem_req, busy, instr_req}), 32'd0);
            end
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
